sample_playback_ctrl: RTL

Address sequencer and sample presenter that sits directly upstream of memory_reading (the synchronous sample ROM). It drives the ROM address at the audio sample rate, captures the returned data after the ROM's fixed read latency, and presents each sample to the downstream effect/DAC stage on a valid/ready handshake. It supports one-shot and looped playback over a programmable address window.

---
 rtl/pedal_pkg.sv | 17 +
 rtl/sample_tick_gen.sv | 31 +++
 rtl/sample_playback_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pedal_pkg.sv
// Shared types and default sizing for the pedal audio path.
// Rate-driven stages import this to agree on state encoding and timing constants.
package pedal_pkg;

   localparam int DEF_ADDR_W      = 10;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_CLK_DIV     = 2267;  // 100 MHz / 44.1 kHz
   localparam int DEF_MEM_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      WAIT_TICK
   } play_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider with a synchronous clear.
// tick is high in the cycle whose closing edge wraps the counter back to 0.
module sample_tick_gen #(
   parameter int CLK_DIV = 2267
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/sample_playback_ctrl.sv
// Walks a ROM address window at the sample rate and presents each sample
// on a valid/ready handshake, in one-shot or looped mode.
module sample_playback_ctrl
   import pedal_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int            FW         = $clog2(MEM_LATENCY + 2);
   localparam logic [FW-1:0] FETCH_LAST = FW'(MEM_LATENCY + 1);

   play_state_t       state;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic [FW-1:0]     fcnt;
   logic              tick_pending;
   logic              tick;
   logic              restart;

   assign restart = start && !stop;
   assign busy    = (state != IDLE);

   sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restart),
      .en    (busy),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem_addr     <= '0;
         start_q      <= '0;
         end_q        <= '0;
         fcnt         <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
         tick_pending <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state        <= IDLE;
            sample_valid <= 1'b0;
            tick_pending <= 1'b0;
         end else if (start) begin
            start_q      <= start_addr;
            end_q        <= end_addr;
            mem_addr     <= start_addr;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            tick_pending <= 1'b0;
            fcnt         <= '0;
            state        <= FETCH;
         end else begin
            // At most one tick may be banked while a sample is still in flight.
            if (tick && (state == FETCH || state == HOLD)) begin
               if (tick_pending) overrun <= 1'b1;
               else              tick_pending <= 1'b1;
            end
            case (state)
               FETCH: begin
                  if (fcnt == FETCH_LAST) begin
                     sample_out   <= mem_data;
                     sample_valid <= 1'b1;
                     state        <= HOLD;
                  end else begin
                     fcnt <= fcnt + FW'(1);
                  end
               end
               HOLD: begin
                  if (sample_ready) begin
                     sample_valid <= 1'b0;
                     if (mem_addr != end_q) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= WAIT_TICK;
                     end else if (loop_en) begin
                        mem_addr <= start_q;
                        state    <= WAIT_TICK;
                     end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
               WAIT_TICK: begin
                  if (tick || tick_pending) begin
                     tick_pending <= 1'b0;
                     fcnt         <= '0;
                     state        <= FETCH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
